// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex word layout and the
// result-collector drain-state encoding.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int N      = 8;
    localparam int IDX_W  = $clog2(N);
    // Butterfly counter spans N/2 pairs.
    localparam int HALF_W = IDX_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_LOAD = 2'd1,
        RD_SEND = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fft_result_collector_if.sv
// Bundle of the collector's butterfly-result input side and its streaming
// output side; master drives results/out_ready, slave is the collector.
interface fft_result_collector_if;
    import fft_pkg::*;

    logic             flush;
    logic             data_out_en;
    logic             data_out_addr;
    cplx_t            res_data;
    logic             collector_ready;
    logic             out_valid;
    logic             out_ready;
    cplx_t            out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             overflow;
    logic             pair_err;

    modport master (
        output flush, data_out_en, data_out_addr, res_data, out_ready,
        input  collector_ready, out_valid, out_data, out_index, out_last,
               overflow, pair_err
    );

    modport slave (
        input  flush, data_out_en, data_out_addr, res_data, out_ready,
        output collector_ready, out_valid, out_data, out_index, out_last,
               overflow, pair_err
    );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong storage of N complex words per bank; one synchronous
// write port and one registered read port addressed by {bank, index}.
module fft_pingpong_ram
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rd_clr,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  cplx_t            wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output cplx_t            rd_data
);

    cplx_t mem [2*N];
    cplx_t rd_data_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
    end

    // The read register doubles as the output data register, so it clears
    // with the collector while the array itself is left untouched.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[{rd_bank, rd_idx}];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fft_result_collector.sv
// Pairs butterfly top/bottom results into a ping-pong frame buffer and
// streams each completed frame out in bin order over valid/ready.
module fft_result_collector
    import fft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fft_result_collector_if.slave bus
);

    logic              clr;
    logic              wbank_reg, wbank_next;
    logic              rbank_reg, rbank_next;
    logic [1:0]        bank_full_reg, bank_full_next;
    logic [HALF_W-1:0] j_reg, j_next;
    logic              pending_reg, pending_next;
    logic              overflow_reg, overflow_next;
    logic              pair_err_reg, pair_err_next;
    rd_state_t         state_reg, state_next;
    logic [IDX_W-1:0]  index_reg, index_next;

    logic              ready;
    logic              we;
    logic [IDX_W-1:0]  wr_idx;
    logic              set_full;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              release_bank;
    cplx_t             rd_data;

    assign clr   = rst | bus.flush;
    assign ready = ~bank_full_reg[wbank_reg];

    // Write side: top results land at j, bottom results at j+N/2.
    always_comb begin
        j_next        = j_reg;
        pending_next  = pending_reg;
        wbank_next    = wbank_reg;
        overflow_next = overflow_reg;
        pair_err_next = 1'b0;
        we            = 1'b0;
        wr_idx        = {1'b0, j_reg};
        set_full      = 1'b0;
        if (bus.data_out_en && !ready) begin
            overflow_next = 1'b1;
        end else if (bus.data_out_en) begin
            if (!bus.data_out_addr) begin
                we            = 1'b1;
                pending_next  = 1'b1;
                pair_err_next = pending_reg;
            end else if (pending_reg) begin
                we           = 1'b1;
                wr_idx       = {1'b1, j_reg};
                pending_next = 1'b0;
                j_next       = j_reg + 1'b1;
                if (&j_reg) begin
                    set_full   = 1'b1;
                    wbank_next = ~wbank_reg;
                end
            end else begin
                pair_err_next = 1'b1;
            end
        end
    end

    // Fill and release always target different banks, so both may land together.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_full_next[gi] =
            (set_full && wbank_reg == 1'(gi))     ? 1'b1 :
            (release_bank && rbank_reg == 1'(gi)) ? 1'b0 :
                                                    bank_full_reg[gi];
    end

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        rbank_next   = rbank_reg;
        rd_en        = 1'b0;
        rd_idx       = '0;
        release_bank = 1'b0;
        case (state_reg)
            RD_IDLE: begin
                if (bank_full_reg[rbank_reg]) begin
                    state_next = RD_LOAD;
                end
            end
            RD_LOAD: begin
                rd_en      = 1'b1;
                index_next = '0;
                state_next = RD_SEND;
            end
            RD_SEND: begin
                if (bus.out_ready) begin
                    if (&index_reg) begin
                        release_bank = 1'b1;
                        rbank_next   = ~rbank_reg;
                        state_next   = RD_IDLE;
                    end else begin
                        rd_en      = 1'b1;
                        rd_idx     = index_reg + 1'b1;
                        index_next = index_reg + 1'b1;
                    end
                end
            end
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wbank_reg     <= 1'b0;
            rbank_reg     <= 1'b0;
            bank_full_reg <= 2'b00;
            j_reg         <= '0;
            pending_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            pair_err_reg  <= 1'b0;
            state_reg     <= RD_IDLE;
            index_reg     <= '0;
        end else begin
            wbank_reg     <= wbank_next;
            rbank_reg     <= rbank_next;
            bank_full_reg <= bank_full_next;
            j_reg         <= j_next;
            pending_reg   <= pending_next;
            overflow_reg  <= overflow_next;
            pair_err_reg  <= pair_err_next;
            state_reg     <= state_next;
            index_reg     <= index_next;
        end
    end

    fft_pingpong_ram u_ram (
        .clk     (clk),
        .rd_clr  (clr),
        .we      (we && !clr),
        .wr_bank (wbank_reg),
        .wr_idx  (wr_idx),
        .wr_data (bus.res_data),
        .rd_en   (rd_en && !clr),
        .rd_bank (rbank_reg),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign bus.collector_ready = ready;
    assign bus.out_valid       = (state_reg == RD_SEND);
    assign bus.out_data        = rd_data;
    assign bus.out_index       = index_reg;
    assign bus.out_last        = (state_reg == RD_SEND) && (&index_reg);
    assign bus.overflow        = overflow_reg;
    assign bus.pair_err        = pair_err_reg;

endmodule

// File: doc/fft_result_collector.md
Name: fft_result_collector

Overview:
Downstream neighbour of the butterfly control FSM. Captures the complex butterfly results that the butterfly stage emits on its output-enable/output-address strobes, pairs each top output (addr 0) with its bottom output (addr 1), and stores them in a two-bank ping-pong buffer indexed by FFT bin. It then streams each completed N-point frame out in index order over a valid/ready interface, so that filling one bank overlaps with draining the other.

Parameters:
DATA_W, 16, width of each real and imaginary component.
N, 8, FFT points per frame; power of 2, at least 4.
IDX_W, $clog2(N), width of the bin index.

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of pairing/pointers/flags; memory contents untouched
data_out_en  in  1  butterfly result strobe
data_out_addr  in  1  0 = top result X[j], 1 = bottom result X[j+N/2]
res_data  in  2*DATA_W  {re, im} result word, valid with data_out_en
collector_ready  out  1  a bank is free to accept writes
out_valid  out  1  out_data/out_index valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_data  out  2*DATA_W  {re, im} bin value
out_index  out  IDX_W  bin index 0..N-1
out_last  out  1  high with index N-1
overflow  out  1  sticky; a strobe was dropped because both banks were full
pair_err  out  1  one-cycle pulse on a pairing violation

Behaviour:
- Reset (rst=1) or flush=1: wbank=0, rbank=0, both bank_full=0, butterfly count j=0, pending=0, out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0, pair_err=0. collector_ready=1 from the next cycle.
- Reset or flush mid-drain abandons the frame. No further beats are issued.
- Pairing, write side:
  - addr0 strobe: writes res_data to index j of wbank and sets pending=1.
  - addr1 strobe with pending=1: writes to index j+N/2, clears pending, increments j.
  - addr1 strobe with pending=0: the word is discarded and pair_err pulses. This covers the stray strobe the butterfly emits on its first DATA_IN cycle.
  - addr0 strobe with pending=1: overwrites index j and pulses pair_err. j is unchanged.
- Bank fill and swap:
  - When j wraps from N/2-1 to 0, bank_full[wbank] is set and wbank toggles in the same cycle.
  - collector_ready = ~bank_full[wbank].
  - A strobe while collector_ready=0 is dropped: no write, no pointer change, overflow=1.
- Drain side, FSM {RD_IDLE, RD_LOAD, RD_SEND}:
  - RD_IDLE -> RD_LOAD when bank_full[rbank]=1.
  - RD_LOAD: registered read of index 0. Next state is RD_SEND with out_valid=1.
  - First beat appears 2 cycles after the filling write.
  - RD_SEND: out_data, out_index and out_last are held stable while out_ready=0.
  - On a handshake with index < N-1, the next index is presented the following cycle, so full throughput at out_ready=1 is 1 beat/cycle.
  - On a handshake with index N-1: clear bank_full[rbank], toggle rbank, return to RD_IDLE.
- Simultaneous events:
  - A write-side fill and a read-side release on different banks in the same cycle are both honoured.
  - A write to a bank in the same cycle it is released is a drop, because the release takes effect next cycle.
- Storage: 2*N words of 2*DATA_W bits, one write port, one read port. No read-during-write on the same bank is possible by construction.

Decomposition:
- Shared package fft_pkg: DATA_W, N, IDX_W, complex word type {re, im}, drain-state encoding. This is the same package the butterfly stage uses.
- One sub-module, fft_pingpong_ram: 2 banks x N words, synchronous write, registered read, bank-select plus index addressing.
- Pairing/pointer logic and the drain FSM stay in fft_result_collector.

Test Plan:
1. Reset: assert rst for 2 cycles with strobes active. Required: all outputs 0 except collector_ready=1 after release, and no memory write occurs.
2. Fill and drain, N=8, out_ready=1:
   - Stimulus: stray addr1 (pair_err pulse, dropped), then pairs (addr0=0x0001_0010, addr1=0x0005_0050), (0x0002_0020, 0x0006_0060), (0x0003_0030, 0x0007_0070), (0x0004_0040, 0x0008_0080).
   - Required: 8 consecutive beats with index 0..7 and data 0x0001_0010, 0x0002_0020, 0x0003_0030, 0x0004_0040, 0x0005_0050, 0x0006_0060, 0x0007_0070, 0x0008_0080, with out_last only on index 7.
   - First beat 2 cycles after the 8th write.
3. Backpressure: same frame with out_ready toggling 1,0,0,1. Required: data held stable while stalled, no index skipped or repeated.
4. Overflow: out_ready=0 and 2 frames written. Required: collector_ready=0 after 16 writes, a 17th strobe is dropped and overflow=1. Releasing out_ready yields frame 1 then frame 2 intact.
5. Pair violations: addr0=0xAAAA_AAAA then addr0=0xBBBB_BBBB then addr1. Required: pair_err pulses once, index 0 reads 0xBBBB_BBBB, j advances once.
6. Flush mid-drain after 3 beats. Required: out_valid=0 the next cycle, overflow cleared, and a new frame drains from index 0.
